// File: rtl/int_ctrl.sv
// Edge-triggered, maskable, non-nesting interrupt controller with fixed lowest-index priority.
// Optional feature: define INTC_SYNC_EN to add a two-flop synchronizer on irq_in.
module int_ctrl #(
   parameter int          N_SRC      = 4,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
   localparam int         ID_W       = $clog2(N_SRC)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] irq_in,
   input  logic             mask_we,
   input  logic [N_SRC-1:0] mask_wd,
   output logic [N_SRC-1:0] mask_rd,
   output logic [N_SRC-1:0] pend_rd,
   output logic             irq,
   input  logic             int_ack,
   input  logic             eoi,
   output logic [ID_W-1:0]  int_id,
   output logic [31:0]      int_vec,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [N_SRC-1:0]   pend_q, pend_d;
   logic [N_SRC-1:0]   mask_q, mask_d;
   logic [N_SRC-1:0]   prev_q, prev_d;
   logic [ID_W-1:0]    int_id_q, int_id_d;
   logic               irq_q, irq_d;
   logic [N_SRC-1:0]   irq_s;
   logic [N_SRC-1:0]   rise;
   logic [N_SRC-1:0]   ack_clr;
   logic [N_SRC-1:0]   pm;
   logic [ID_W-1:0]    win_id;

`ifdef INTC_SYNC_EN
   logic [N_SRC-1:0]   sync1_q, sync2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= irq_in;
         sync2_q <= sync1_q;
      end
   end

   assign irq_s = sync2_q;
`else
   assign irq_s = irq_in;
`endif

   // prev_q resets to 0, so a source already high at reset release counts as an edge.
   assign rise   = irq_s & ~prev_q;
   assign prev_d = irq_s;
   assign pm     = pend_q & mask_q;

   // Lowest set index wins: scan downward so the last hit is the smallest index.
   always_comb begin
      win_id = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (pm[i]) win_id = ID_W'(i);
      end
   end

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      int_id_d = int_id_q;
      ack_clr  = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (pm != '0) begin
               int_id_d = win_id;
               state_d  = ST_REQ;
            end
         end
         ST_REQ: begin
            if (int_ack) begin
               ack_clr[int_id_q] = 1'b1;
               state_d           = ST_SERVICE;
            end else if (!(pend_q[int_id_q] && mask_q[int_id_q])) begin
               state_d = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (eoi) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      irq_d = (state_d == ST_REQ);
   end

   // A new edge beats a same-cycle acknowledge clear.
   assign pend_d = (pend_q & ~ack_clr) | rise;
   assign mask_d = mask_we ? mask_wd : mask_q;

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         pend_q   <= '0;
         mask_q   <= '0;
         prev_q   <= '0;
         int_id_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         mask_q   <= mask_d;
         prev_q   <= prev_d;
         int_id_q <= int_id_d;
         irq_q    <= irq_d;
      end
   end

   assign mask_rd = mask_q;
   assign pend_rd = pend_q;
   assign irq     = irq_q;
   assign int_id  = int_id_q;
   assign busy    = (state_q == ST_SERVICE);
   assign int_vec = VEC_BASE + (32'(int_id_q) * VEC_STRIDE);

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: expectations queued when stimulus is driven, popped when outputs are sampled.
module tb_int_ctrl;

   localparam int N_SRC = 4;
`ifdef INTC_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N_SRC-1:0] irq_in;
   logic             mask_we;
   logic [N_SRC-1:0] mask_wd;
   logic [N_SRC-1:0] mask_rd;
   logic [N_SRC-1:0] pend_rd;
   logic             irq;
   logic             int_ack;
   logic             eoi;
   logic [1:0]       int_id;
   logic [31:0]      int_vec;
   logic             busy;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   int_ctrl #(.N_SRC(N_SRC)) dut (
      .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask_we(mask_we), .mask_wd(mask_wd),
      .mask_rd(mask_rd), .pend_rd(pend_rd), .irq(irq), .int_ack(int_ack), .eoi(eoi),
      .int_id(int_id), .int_vec(int_vec), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      n_assert++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %h required a queued expectation", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
         end
      end
   endtask

   // Advance n rising edges, then settle on the following falling edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic write_mask(input logic [N_SRC-1:0] m);
      mask_we = 1'b1;
      mask_wd = m;
      tick(1);
      mask_we = 1'b0;
   endtask

   task automatic pulse_ack();
      int_ack = 1'b1;
      tick(1);
      int_ack = 1'b0;
   endtask

   task automatic pulse_eoi();
      eoi = 1'b1;
      tick(1);
      eoi = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      irq_in  = '0;
      mask_we = 1'b0;
      mask_wd = '0;
      int_ack = 1'b0;
      eoi     = 1'b0;
      tick(2);

      // Reset state
      expect_val("rst_irq", 0);       check(32'(irq));
      expect_val("rst_busy", 0);      check(32'(busy));
      expect_val("rst_pend", 0);      check(32'(pend_rd));
      expect_val("rst_mask", 0);      check(32'(mask_rd));
      expect_val("rst_id", 0);        check(32'(int_id));
      expect_val("rst_vec", 32'h100); check(int_vec);
      rst_n = 1'b1;
      tick(1);

      // Single source 2, full mask
      write_mask(4'hF);
      expect_val("mask_f", 4'hF); check(32'(mask_rd));
      irq_in[2] = 1'b1;
      expect_val("s2_pend", 4'b0100);
      expect_val("s2_irq_early", 0);
      tick(LAT);
      check(32'(pend_rd));
      check(32'(irq));
      expect_val("s2_irq", 1);
      expect_val("s2_id", 2);
      expect_val("s2_vec", 32'h0000_0120);
      tick(1);
      check(32'(irq));
      check(32'(int_id));
      check(int_vec);
      pulse_ack();
      expect_val("s2_ack_irq", 0);      check(32'(irq));
      expect_val("s2_ack_busy", 1);     check(32'(busy));
      expect_val("s2_ack_pend", 0);     check(32'(pend_rd));
      pulse_eoi();
      expect_val("s2_eoi_busy", 0);     check(32'(busy));
      tick(LAT + 2);
      expect_val("s2_held_pend", 0);    check(32'(pend_rd));
      expect_val("s2_held_irq", 0);     check(32'(irq));
      irq_in = '0;
      tick(LAT + 1);

      // Sources 1 and 3 together: 1 first, then 3
      irq_in = 4'b1010;
      tick(LAT + 1);
      expect_val("p13_pend", 4'b1010); check(32'(pend_rd));
      expect_val("p13_id", 1);         check(32'(int_id));
      expect_val("p13_irq", 1);        check(32'(irq));
      pulse_eoi();
      expect_val("eoi_in_req_irq", 1); check(32'(irq));
      pulse_ack();
      expect_val("p13_pend_ack", 4'b1000); check(32'(pend_rd));
      expect_val("p13_busy", 1);            check(32'(busy));
      int_ack = 1'b1;
      tick(1);
      int_ack = 1'b0;
      expect_val("ack_in_svc_pend", 4'b1000); check(32'(pend_rd));
      pulse_eoi();
      expect_val("p13_idle_irq", 0); check(32'(irq));
      tick(1);
      expect_val("p3_irq", 1);            check(32'(irq));
      expect_val("p3_id", 3);             check(32'(int_id));
      expect_val("p3_vec", 32'h130);      check(int_vec);
      pulse_ack();
      pulse_eoi();
      irq_in = '0;
      tick(LAT + 1);

      // Masked source 0, then unmask
      write_mask(4'b0000);
      irq_in[0] = 1'b1;
      tick(LAT + 1);
      expect_val("m0_pend", 4'b0001); check(32'(pend_rd));
      expect_val("m0_irq", 0);        check(32'(irq));
      write_mask(4'b0001);
      expect_val("m0_irq_wr", 0);     check(32'(irq));
      tick(1);
      expect_val("m0_irq_on", 1);     check(32'(irq));
      expect_val("m0_id", 0);         check(32'(int_id));

      // Mask withdrawn while in REQ for source 0
      write_mask(4'b0000);
      tick(1);
      expect_val("wd_irq", 0);   check(32'(irq));
      expect_val("wd_pend", 1);  check(32'(pend_rd[0]));
      expect_val("wd_busy", 0);  check(32'(busy));
      tick(2);
      expect_val("wd_idle_irq", 0); check(32'(irq));

      // Acknowledge coinciding with a fresh source 0 edge
      write_mask(4'b0001);
      tick(1);
      expect_val("re_irq", 1); check(32'(irq));
      irq_in[0] = 1'b0;
      tick(LAT + 1);
      irq_in[0] = 1'b1;
      if (LAT > 1) tick(LAT - 1);
      pulse_ack();
      expect_val("setwin_pend", 1); check(32'(pend_rd[0]));
      expect_val("setwin_busy", 1); check(32'(busy));
      expect_val("setwin_irq", 0);  check(32'(irq));

      // Asynchronous reset in SERVICE
      #2;
      rst_n = 1'b0;
      #1;
      expect_val("ar_irq", 0);  check(32'(irq));
      expect_val("ar_busy", 0); check(32'(busy));
      expect_val("ar_pend", 0); check(32'(pend_rd));
      expect_val("ar_mask", 0); check(32'(mask_rd));
      tick(1);

      // irq_in[0] still high at release is taken as an edge
      rst_n = 1'b1;
      write_mask(4'hF);
      if (LAT > 1) tick(LAT - 1);
      expect_val("rel_pend", 4'b0001); check(32'(pend_rd));
      tick(1);
      expect_val("rel_irq", 1); check(32'(irq));

      if (exp_q.size() != 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL scoreboard_leftover: observed %0d entries required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of interrupt sources (2..8).
REQ-002 SHALL have parameter VEC_BASE, default 32'h0000_0100, address of source 0 handler.
REQ-003 SHALL have parameter VEC_STRIDE, default 32'h0000_0010, byte spacing between handler vectors.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port irq_in  input  N_SRC  latched device done/interrupt flags; rising edge = event.
REQ-007 SHALL have port mask_we  input  1  write strobe for the mask register.
REQ-008 SHALL have port mask_wd  input  N_SRC  mask write data; 1 = enabled.
REQ-009 SHALL have port mask_rd  output  N_SRC  current mask register.
REQ-010 SHALL have port pend_rd  output  N_SRC  current pending register.
REQ-011 SHALL have port irq  output  1  interrupt request to CPU.
REQ-012 SHALL have port int_ack  input  1  one-cycle CPU acceptance pulse.
REQ-013 SHALL have port eoi  input  1  one-cycle end-of-interrupt pulse from handler.
REQ-014 SHALL have port int_id  output  $clog2(N_SRC)  selected source index.
REQ-015 SHALL have port int_vec  output  32  handler address for int_id.
REQ-016 SHALL have port busy  output  1  high while in SERVICE.

Function
REQ-017 SHALL detect a rising edge per bit of the (optionally synchronized) irq_in against a registered previous value; each edge sets that pending bit.
REQ-018 SHALL, when an edge sets and an int_ack clears the same pending bit in one cycle, leave the bit set (set wins).
REQ-019 SHALL implement states IDLE, REQ, SERVICE.
REQ-020 SHALL in IDLE, when (pend & mask) != 0, register int_id = lowest set index of (pend & mask) and go to REQ; irq is a registered output, high in REQ only.
REQ-021 SHALL in REQ, on int_ack, clear pend[int_id], go to SERVICE, and drop irq on the same edge.
REQ-022 SHALL in REQ without int_ack, return to IDLE if pend[int_id] & mask[int_id] becomes 0 (masked); int_id is not re-arbitrated while in REQ.
REQ-023 SHALL in SERVICE hold int_id, ignore new arbitration (no nesting), go to IDLE on eoi.
REQ-024 SHALL ignore int_ack outside REQ and eoi outside SERVICE.
REQ-025 SHALL drive int_vec = VEC_BASE + int_id*VEC_STRIDE, 32-bit modulo arithmetic, combinationally from registered int_id.
REQ-026 SHALL update the mask on mask_we at the clock edge; mask changes never clear pending bits.
REQ-027 SHALL keep irq_in held high from causing further events; only a new 0->1 transition re-sets pending.

Reset
REQ-028 SHALL on rst_n low asynchronously force state IDLE, irq 0, busy 0, int_id 0, pend 0, mask 0, edge and synchronizer flops 0, including mid-REQ or mid-SERVICE.
REQ-029 SHALL treat irq_in bits already high on reset release as edges at their first sample.

Configuration
REQ-030 SHALL, with macro INTC_SYNC_EN defined, pass irq_in through a two-flop synchronizer before edge detection: pend bit set at 3rd rising edge after irq_in rises, irq high at 4th.
REQ-031 SHALL, without INTC_SYNC_EN, edge-detect irq_in directly: pend bit set at 1st rising edge, irq high at 2nd; all other behaviour identical.

Verification
REQ-032 SHALL cover: mask=4'b1111, irq_in[2] 0->1 -> pend_rd=4'b0100, irq=1, int_id=2, int_vec=32'h0000_0120 at REQ-030/031 latency.
REQ-033 SHALL cover: irq_in[1] and irq_in[3] rise same cycle -> int_id=1; after int_ack+eoi, int_id=3 next.
REQ-034 SHALL cover: mask=4'b0000, irq_in[0] rises -> pend_rd=4'b0001, irq=0; then mask_wd=4'b0001 write -> irq=1 one cycle later.
REQ-035 SHALL cover: in REQ for source 0, mask 0 cleared -> irq=0 next edge, pend_rd[0] still 1, state IDLE.
REQ-036 SHALL cover: int_ack on same cycle as new irq_in[0] edge for id 0 -> pend_rd[0]=1, state SERVICE, busy=1.
REQ-037 SHALL cover: rst_n low during SERVICE -> irq=0, busy=0, pend_rd=0, mask_rd=0 immediately, before the next clk edge.
